// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared constants and types for the sprite ROM arbitration path.
//   SPRITE_ADDR_W / SPRITE_DATA_W : default sprite ROM address / word widths
//   SPRITE_MAX_REQ                : largest supported requester count
//   req_id_t                      : requester index
//   rom_tag_t                     : in-flight read tag {valid, id}
// -----------------------------------------------------------------------------
package sprite_pkg;

   localparam int unsigned SPRITE_ADDR_W  = 12;
   localparam int unsigned SPRITE_DATA_W  = 4;
   localparam int unsigned SPRITE_MAX_REQ = 8;

   // Sized for the largest configuration so every build shares one tag type.
   typedef logic [$clog2(SPRITE_MAX_REQ)-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rom_tag_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Search starts just after the last grant
// and wraps modulo NUM_REQ; the first set request wins.
//   i_req   : request vector
//   i_last  : index of the previous grant
//   o_grant : one-hot grant (zero when no request)
//   o_id    : index of the granted requester
//   o_any   : a grant was made
// -----------------------------------------------------------------------------
module rr_pick
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  req_id_t            i_last,
   output logic [NUM_REQ-1:0] o_grant,
   output req_id_t            o_id,
   output logic               o_any
);

   logic w_found;

   always_comb begin
      o_grant = '0;
      o_id    = '0;
      w_found = 1'b0;
      // First pass covers indices above the last grant, second pass wraps to 0.
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (!w_found && i_req[j] && (j > int'(i_last))) begin
            o_grant[j] = 1'b1;
            o_id       = req_id_t'(j);
            w_found    = 1'b1;
         end
      end
      for (int j = 0; j < int'(NUM_REQ); j++) begin
         if (!w_found && i_req[j] && (j <= int'(i_last))) begin
            o_grant[j] = 1'b1;
            o_id       = req_id_t'(j);
            w_found    = 1'b1;
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
// Shares one synchronous sprite ROM among NUM_REQ draw units. One read is
// granted per cycle by round-robin; a tag pipeline follows each read through
// the ROM latency and returns the word to its issuer as a one-cycle pulse.
//   vga_clk / reset_n : pixel clock, async active-low reset
//   req_valid/req_addr: per-requester read requests (packed addresses)
//   req_ready         : one-hot grant
//   rom_rd/rom_addr   : registered ROM read strobe and address
//   rom_q             : ROM data, valid ROM_LAT cycles after rom_rd
//   rsp_valid/rsp_data: registered one-hot response pulse and shared word
// -----------------------------------------------------------------------------
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = SPRITE_ADDR_W,
   parameter int unsigned DATA_W  = SPRITE_DATA_W,
   parameter int unsigned ROM_LAT = 1
) (
   input  logic                      vga_clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      rom_rd,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_q,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data
);

   // Stage 0 lines up with rom_rd; stage ROM_LAT lines up with valid rom_q.
   localparam int unsigned NUM_STG = ROM_LAT + 1;

   req_id_t             r_last_grant;
   logic                r_rom_rd;
   logic [ADDR_W-1:0]   r_rom_addr;
   rom_tag_t            r_tag [NUM_STG];
   logic [NUM_REQ-1:0]  r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data;

   logic [NUM_REQ-1:0]  w_grant;
   req_id_t             w_id;
   logic                w_any;
   logic [ADDR_W-1:0]   w_addr;
   rom_tag_t            w_head;
   logic [NUM_REQ-1:0]  w_rsp_onehot;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .i_req   (req_valid),
      .i_last  (r_last_grant),
      .o_grant (w_grant),
      .o_id    (w_id),
      .o_any   (w_any)
   );

   // One-hot grant selects the winning address without a variable index.
   always_comb begin
      w_addr = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (w_grant[i]) begin
            w_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign w_head = r_tag[ROM_LAT];

   always_comb begin
      w_rsp_onehot = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_rsp_onehot[i] = w_head.valid && (w_head.id == req_id_t'(i));
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= req_id_t'(NUM_REQ - 1);
         r_rom_rd     <= 1'b0;
         r_rom_addr   <= '0;
         r_rsp_valid  <= '0;
         r_rsp_data   <= '0;
         for (int k = 0; k < int'(NUM_STG); k++) begin
            r_tag[k] <= '0;
         end
      end else begin
         r_rom_rd <= w_any;
         if (w_any) begin
            r_last_grant <= w_id;
            r_rom_addr   <= w_addr;
         end
         r_tag[0] <= '{valid: w_any, id: w_id};
         for (int k = 1; k < int'(NUM_STG); k++) begin
            r_tag[k] <= r_tag[k-1];
         end
         r_rsp_valid <= w_rsp_onehot;
         if (w_head.valid) begin
            r_rsp_data <= rom_q;
         end
      end
   end

   assign req_ready = w_grant;
   assign rom_rd    = r_rom_rd;
   assign rom_addr  = r_rom_addr;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule
